arbitro_memoria_dados: RTL and testbench

- Two-master arbiter and sequencer in front of the 16-bit data memory (registered-read, write-enable + address + data interface).
- Master 0 is the processor load/store path; master 1 is the I/O/DMA port.
- Round-robin arbitration, one memory access at a time, registered memory-side signals, read data returned with a valid pulse.

---
 rtl/arbitro_memoria_dados_pkg.sv | 16 +
 rtl/arbitro_memoria_dados_if.sv | 39 +++
 rtl/arbitro_memoria_dados_rr.sv | 25 ++
 rtl/arbitro_memoria_dados.sv | 110 +++++++++++
 tb/tb_arbitro_memoria_dados.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_memoria_dados_pkg.sv
// Shared types and constants for the data-memory arbiter.
package pkg_memoria;

  localparam int BITS_PALAVRA  = 16;
  localparam int END_REGISTROS = 16;

  // Identifies which master owns the current access.
  typedef logic id_mestre_t;

  typedef enum logic [1:0] {
    OCIOSO,
    ACESSO,
    RESPOSTA
  } estado_arb_t;

endpackage

// File: rtl/arbitro_memoria_dados_if.sv
// Bus bundle between the two masters, the arbiter and the data memory.
interface arbitro_memoria_dados_if
  import pkg_memoria::*;
#(
  parameter int bits_palavra  = BITS_PALAVRA,
  parameter int end_registros = END_REGISTROS
);

  // Master-side handshake
  logic                     req0, req1;
  logic                     we0, we1;
  logic [end_registros-1:0] addr0, addr1;
  logic [bits_palavra-1:0]  wdata0, wdata1;
  logic                     gnt0, gnt1;
  logic                     rvalid0, rvalid1;
  logic [bits_palavra-1:0]  rdata;
  logic                     ocupado;

  // Memory-side port
  logic                     mem_hab_escrita;
  logic [end_registros-1:0] mem_endereco;
  logic [bits_palavra-1:0]  mem_entrada;
  logic [bits_palavra-1:0]  mem_saida;

  // Arbiter view
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_saida,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, ocupado,
           mem_hab_escrita, mem_endereco, mem_entrada
  );

  // Masters plus memory view (the environment around the arbiter)
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_saida,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, ocupado,
           mem_hab_escrita, mem_endereco, mem_entrada
  );

endinterface

// File: rtl/arbitro_memoria_dados_rr.sv
// Combinational two-input round-robin pick.
module rr_arbitro_2
  import pkg_memoria::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  id_mestre_t i_prioridade,
  output id_mestre_t o_vencedor,
  output logic       o_valido
);

  assign o_valido = i_req0 | i_req1;

  // Lone requester wins; on contention the prioritised master wins.
  always_comb begin
    // NOTE: default assignment first so no path leaves o_vencedor unassigned (no latch).
    o_vencedor = 1'b0;
    if (i_req0 && i_req1) begin
      o_vencedor = i_prioridade;
    end else if (i_req1) begin
      o_vencedor = 1'b1;
    end
  end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Two-master round-robin arbiter and access sequencer for the data memory.
module arbitro_memoria_dados
  import pkg_memoria::*;
#(
  parameter int bits_palavra  = BITS_PALAVRA,
  parameter int end_registros = END_REGISTROS
) (
  input  logic                    clock,
  input  logic                    reset,
  arbitro_memoria_dados_if.slave  bus
);

  estado_arb_t              r_estado;
  id_mestre_t               r_prioridade;
  id_mestre_t               r_vencedor;
  logic                     r_gnt0, r_gnt1;
  logic                     r_rvalid0, r_rvalid1;
  logic                     r_ocupado;
  logic                     r_mem_hab_escrita;
  logic [end_registros-1:0] r_mem_endereco;
  logic [bits_palavra-1:0]  r_mem_entrada;

  id_mestre_t               w_vencedor;
  logic                     w_valido;
  logic                     w_we_sel;
  logic [end_registros-1:0] w_addr_sel;
  logic [bits_palavra-1:0]  w_wdata_sel;

  rr_arbitro_2 u_rr (
    .i_req0       (bus.req0),
    .i_req1       (bus.req1),
    .i_prioridade (r_prioridade),
    .o_vencedor   (w_vencedor),
    .o_valido     (w_valido)
  );

  assign w_we_sel    = w_vencedor ? bus.we1    : bus.we0;
  assign w_addr_sel  = w_vencedor ? bus.addr1  : bus.addr0;
  assign w_wdata_sel = w_vencedor ? bus.wdata1 : bus.wdata0;

  // Sequencer FSM: grant, one-cycle memory access, optional read response.
  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: memory-side registers are reset too, so the bus is quiet while reset is held.
      r_estado          <= OCIOSO;
      r_prioridade      <= 1'b0;
      r_vencedor        <= 1'b0;
      r_gnt0            <= 1'b0;
      r_gnt1            <= 1'b0;
      r_rvalid0         <= 1'b0;
      r_rvalid1         <= 1'b0;
      r_ocupado         <= 1'b0;
      r_mem_hab_escrita <= 1'b0;
      r_mem_endereco    <= '0;
      r_mem_entrada     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (w_valido) begin
            r_vencedor        <= w_vencedor;
            r_prioridade      <= ~w_vencedor;
            r_gnt0            <= ~w_vencedor;
            r_gnt1            <= w_vencedor;
            r_mem_endereco    <= w_addr_sel;
            r_mem_entrada     <= w_we_sel ? w_wdata_sel : '0;
            r_mem_hab_escrita <= w_we_sel;
            r_ocupado         <= 1'b1;
            r_estado          <= ACESSO;
          end
        end
        ACESSO: begin
          r_mem_hab_escrita <= 1'b0;
          if (r_mem_hab_escrita) begin
            r_ocupado <= 1'b0;
            r_estado  <= OCIOSO;
          end else begin
            r_rvalid0 <= ~r_vencedor;
            r_rvalid1 <= r_vencedor;
            r_estado  <= RESPOSTA;
          end
        end
        RESPOSTA: begin
          r_ocupado <= 1'b0;
          r_estado  <= OCIOSO;
        end
        default: begin
          r_ocupado <= 1'b0;
          r_estado  <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.gnt0         = r_gnt0;
  assign bus.gnt1         = r_gnt1;
  assign bus.rvalid0      = r_rvalid0;
  assign bus.rvalid1      = r_rvalid1;
  assign bus.ocupado      = r_ocupado;
  assign bus.mem_endereco = r_mem_endereco;
  assign bus.mem_entrada  = r_mem_entrada;
  // Write enable is qualified by reset so a write caught by reset never reaches the memory.
  assign bus.mem_hab_escrita = r_mem_hab_escrita & reset;
  assign bus.rdata           = (r_rvalid0 | r_rvalid1) ? bus.mem_saida : '0;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Directed self-checking bench for arbitro_memoria_dados with a registered-read memory model.
module tb_arbitro_memoria_dados;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  logic [15:0] mem [0:255];

  arbitro_memoria_dados_if bus ();

  arbitro_memoria_dados dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data memory: write on enable, registered read of the presented address.
  always @(posedge clock) begin
    if (bus.mem_hab_escrita) mem[bus.mem_endereco[7:0]] <= bus.mem_entrada;
    bus.mem_saida <= mem[bus.mem_endereco[7:0]];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_reqs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h03] = 16'h0BEE;
    mem[8'h20] = 16'h5555;

    // Reset held 3 cycles while master 0 requests a read of 0x0003
    idle_reqs();
    reset = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 16'h0003;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_gnt0",   {31'd0, bus.gnt0},         32'd0);
      check("rst_ocup",   {31'd0, bus.ocupado},      32'd0);
      check("rst_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
      check("rst_we",     {31'd0, bus.mem_hab_escrita}, 32'd0);
      check("rst_addr",   {16'd0, bus.mem_endereco}, 32'd0);
      check("rst_din",    {16'd0, bus.mem_entrada},  32'd0);
      check("rst_rdata",  {16'd0, bus.rdata},        32'd0);
    end
    reset = 1'b1;
    tick();
    check("rel_gnt0",  {31'd0, bus.gnt0},         32'd1);
    check("rel_ocup",  {31'd0, bus.ocupado},      32'd1);
    check("rel_addr",  {16'd0, bus.mem_endereco}, 32'h0003);
    check("rel_we",    {31'd0, bus.mem_hab_escrita}, 32'd0);
    bus.req0 = 1'b0;
    tick();
    check("rel_rv0",   {31'd0, bus.rvalid0},      32'd1);
    check("rel_rdata", {16'd0, bus.rdata},        32'h0BEE);
    check("rel_gnt0b", {31'd0, bus.gnt0},         32'd0);
    tick();
    check("rel_rv0_end", {31'd0, bus.rvalid0},    32'd0);
    check("rel_rdata0",  {16'd0, bus.rdata},      32'd0);
    check("rel_idle",    {31'd0, bus.ocupado},    32'd0);

    // Single write by master 0
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0010; bus.wdata0 = 16'hABCD;
    tick();
    check("wr_gnt0", {31'd0, bus.gnt0},            32'd1);
    check("wr_we",   {31'd0, bus.mem_hab_escrita}, 32'd1);
    check("wr_addr", {16'd0, bus.mem_endereco},    32'h0010);
    check("wr_din",  {16'd0, bus.mem_entrada},     32'hABCD);
    check("wr_ocup", {31'd0, bus.ocupado},         32'd1);
    idle_reqs();
    tick();
    check("wr_we_off",  {31'd0, bus.mem_hab_escrita}, 32'd0);
    check("wr_ocup_off",{31'd0, bus.ocupado},         32'd0);
    check("wr_gnt_off", {31'd0, bus.gnt0},            32'd0);

    // Read-back by master 1
    bus.req1 = 1'b1; bus.addr1 = 16'h0010;
    tick();
    check("rb_gnt1", {31'd0, bus.gnt1},         32'd1);
    check("rb_gnt0", {31'd0, bus.gnt0},         32'd0);
    check("rb_din",  {16'd0, bus.mem_entrada},  32'd0);
    idle_reqs();
    tick();
    check("rb_rv1",   {31'd0, bus.rvalid1},     32'd1);
    check("rb_rv0",   {31'd0, bus.rvalid0},     32'd0);
    check("rb_rdata", {16'd0, bus.rdata},       32'hABCD);
    tick();
    check("rb_done",  {31'd0, bus.rvalid1},     32'd0);

    // Contention: both masters write continuously, grants must alternate 0,1,0,1
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0030; bus.wdata0 = 16'h1111;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0040; bus.wdata1 = 16'h2222;
    tick();
    check("ct1_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'b01);
    check("ct1_addr",{16'd0, bus.mem_endereco},   32'h0030);
    tick();
    check("ct1_gap", {30'd0, bus.gnt1, bus.gnt0}, 32'b00);
    tick();
    check("ct2_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'b10);
    check("ct2_din", {16'd0, bus.mem_entrada},    32'h2222);
    tick();
    check("ct2_gap", {30'd0, bus.gnt1, bus.gnt0}, 32'b00);
    tick();
    check("ct3_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'b01);
    tick();
    tick();
    check("ct4_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'b10);
    idle_reqs();
    tick();
    tick();
    check("ct_quiet", {29'd0, bus.ocupado, bus.gnt1, bus.gnt0}, 32'd0);

    // Reset during the ACESSO cycle of a write drops that write
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0020; bus.wdata0 = 16'h1234;
    tick();
    check("rw_gnt0", {31'd0, bus.gnt0},            32'd1);
    check("rw_we",   {31'd0, bus.mem_hab_escrita}, 32'd1);
    idle_reqs();
    reset = 1'b0;
    #1;
    check("rw_we_gated", {31'd0, bus.mem_hab_escrita}, 32'd0);
    tick();
    check("rw_we_rst",  {31'd0, bus.mem_hab_escrita}, 32'd0);
    check("rw_ocup",    {31'd0, bus.ocupado},         32'd0);
    check("rw_rv",      {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    reset = 1'b1;
    tick();
    bus.req1 = 1'b1; bus.addr1 = 16'h0020;
    tick();
    check("rw_rd_gnt1", {31'd0, bus.gnt1},  32'd1);
    idle_reqs();
    tick();
    check("rw_rd_rv1",  {31'd0, bus.rvalid1}, 32'd1);
    check("rw_rd_data", {16'd0, bus.rdata},   32'h5555);
    tick();

    // Held request with no competitor: one grant per idle visit
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0050; bus.wdata0 = 16'h0777;
    tick();
    check("hd_g1", {31'd0, bus.gnt0}, 32'd1);
    tick();
    check("hd_n1", {31'd0, bus.gnt0}, 32'd0);
    tick();
    check("hd_g2", {31'd0, bus.gnt0}, 32'd1);
    tick();
    check("hd_n2", {31'd0, bus.gnt0}, 32'd0);
    idle_reqs();
    tick();
    check("hd_stop", {30'd0, bus.ocupado, bus.gnt0}, 32'd0);

    // Contended reads: last grant went to master 0, so master 1 goes first
    bus.req0 = 1'b1; bus.addr0 = 16'h0030;
    bus.req1 = 1'b1; bus.addr1 = 16'h0040;
    tick();
    check("cr1_gnt",  {30'd0, bus.gnt1, bus.gnt0}, 32'b10);
    check("cr1_addr", {16'd0, bus.mem_endereco},   32'h0040);
    tick();
    check("cr1_rv",   {30'd0, bus.rvalid1, bus.rvalid0}, 32'b10);
    check("cr1_data", {16'd0, bus.rdata},          32'h2222);
    tick();
    check("cr1_idle", {30'd0, bus.gnt1, bus.gnt0}, 32'b00);
    tick();
    check("cr2_gnt",  {30'd0, bus.gnt1, bus.gnt0}, 32'b01);
    idle_reqs();
    tick();
    check("cr2_rv",   {30'd0, bus.rvalid1, bus.rvalid0}, 32'b01);
    check("cr2_data", {16'd0, bus.rdata},          32'h1111);
    tick();
    check("cr2_idle", {16'd0, bus.rdata},          32'd0);

    // Written value from the held-request sequence reached memory
    bus.req0 = 1'b1; bus.addr0 = 16'h0050;
    tick();
    idle_reqs();
    tick();
    check("hd_rdata", {16'd0, bus.rdata}, 32'h0777);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
